mac_op_scheduler: RTL and testbench

Shares the single MAC datapath and its sequencing controller among `NREQ` requesters (routing-iteration engines, squash and column-sum stages). It arbitrates round-robin, converts a granted 3-bit opcode into the one-cycle start pulse the MAC controller expects (`sq`, `sc`, `mat8`, `mat16`, `col_sum`), and waits for the controller's `done`. It then acknowledges the requester, with a watchdog that recovers from a missing `done`.

---
 rtl/mac_op_scheduler_pkg.sv | 30 +++
 rtl/mac_op_scheduler_if.sv | 30 +++
 rtl/mac_op_scheduler_rr_arbiter.sv | 30 +++
 rtl/mac_op_scheduler.sv | 122 ++++++++++++
 tb/tb_mac_op_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_op_scheduler_pkg.sv
// Shared opcode, state and start-line definitions for the MAC operation scheduler.
package mac_sched_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SQ     = 3'd0;
    localparam logic [OP_W-1:0] OP_SC     = 3'd1;
    localparam logic [OP_W-1:0] OP_MAT8   = 3'd2;
    localparam logic [OP_W-1:0] OP_MAT16  = 3'd3;
    localparam logic [OP_W-1:0] OP_COLSUM = 3'd4;

    localparam int NSTART = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } sched_state_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_COLSUM;
    endfunction

    // Bit n of the result drives the start line for opcode n.
    function automatic logic [NSTART-1:0] start_onehot(input logic [OP_W-1:0] op);
        return NSTART'(1) << op;
    endfunction

endpackage

// File: rtl/mac_op_scheduler_if.sv
// Requester / MAC-controller bundle between the scheduler and its environment.
interface mac_op_scheduler_if #(
    parameter int NREQ = 4
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] op;
    logic              mac_done;
    logic              sq;
    logic              sc;
    logic              mat8;
    logic              mat16;
    logic              col_sum;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              busy;
    logic [IDX_W-1:0]  grant_id;
    logic [15:0]       ops_done;

    modport master (
        output req, op, mac_done,
        input  sq, sc, mat8, mat16, col_sum, ack, err, busy, grant_id, ops_done
    );

    modport slave (
        input  req, op, mac_done,
        output sq, sc, mat8, mat16, col_sum, ack, err, busy, grant_id, ops_done
    );
endinterface

// File: rtl/mac_op_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDX_W-1:0]  enc;
    logic [IDX_W:0]    sum;

    assign dbl = {req, req};
    assign rot = dbl[ptr +: NREQ];
    assign any = |req;

    always_comb begin
        enc = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) enc = IDX_W'(j);
        end
        // Undo the rotation; the sum never exceeds 2*NREQ-2 so one subtract suffices.
        sum = {1'b0, enc} + {1'b0, ptr};
        if (sum >= (IDX_W + 1)'(NREQ)) sum = sum - (IDX_W + 1)'(NREQ);
        idx = sum[IDX_W-1:0];
    end
endmodule

// File: rtl/mac_op_scheduler.sv
// Round-robin scheduler sharing one MAC controller among NREQ requesters, with a done watchdog.
module mac_op_scheduler
    import mac_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2047
) (
    input  logic         clk,
    input  logic         rst,
    mac_op_scheduler_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    sched_state_t      state_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [OP_W-1:0]   opc_q;
    logic              err_flag_q;
    logic [WD_W-1:0]   wdog_q;
    logic [NSTART-1:0] start_q;
    logic [NREQ-1:0]   ack_q;
    logic              err_q;
    logic [15:0]       ops_done_q;

    logic              arb_any;
    logic [IDX_W-1:0]  arb_idx;
    logic [OP_W-1:0]   arb_op;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .any (arb_any),
        .idx (arb_idx)
    );

    assign arb_op = bus.op[arb_idx*OP_W +: OP_W];

    function automatic logic [NREQ-1:0] req_onehot(input logic [IDX_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NREQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            opc_q      <= '0;
            err_flag_q <= 1'b0;
            wdog_q     <= '0;
            start_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            ops_done_q <= '0;
        end else begin
            // Pulse outputs default low; each is raised on the transition that precedes its cycle.
            start_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_q <= arb_idx;
                        opc_q   <= arb_op;
                        if (op_legal(arb_op)) begin
                            start_q <= start_onehot(arb_op);
                            state_q <= ST_ISSUE;
                        end else begin
                            err_flag_q <= 1'b1;
                            ack_q      <= req_onehot(arb_idx);
                            err_q      <= 1'b1;
                            state_q    <= ST_ACK;
                        end
                    end
                end
                ST_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mac_done) begin
                        ack_q   <= req_onehot(grant_q);
                        state_q <= ST_ACK;
                    end else if (wdog_q == WD_W'(TIMEOUT)) begin
                        err_flag_q <= 1'b1;
                        ack_q      <= req_onehot(grant_q);
                        err_q      <= 1'b1;
                        state_q    <= ST_ACK;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                ST_ACK: begin
                    if (!err_flag_q) ops_done_q <= sat_inc(ops_done_q);
                    rr_ptr_q   <= ptr_next(grant_q);
                    err_flag_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.sq       = start_q[OP_SQ];
    assign bus.sc       = start_q[OP_SC];
    assign bus.mat8     = start_q[OP_MAT8];
    assign bus.mat16    = start_q[OP_MAT16];
    assign bus.col_sum  = start_q[OP_COLSUM];
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.grant_id = grant_q;
    assign bus.ops_done = ops_done_q;
endmodule

// File: tb/tb_mac_op_scheduler.sv
// Directed self-checking bench for mac_op_scheduler (NREQ=4, TIMEOUT=15).
module tb_mac_op_scheduler;
    localparam int NREQ = 4;
    localparam int TO   = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mac_op_scheduler_if #(.NREQ(NREQ)) ifc ();

    mac_op_scheduler #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit n corresponds to opcode n.
    function automatic logic [4:0] starts();
        return {ifc.col_sum, ifc.mat16, ifc.mat8, ifc.sc, ifc.sq};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst          = 1'b1;
        ifc.req      = '0;
        ifc.op       = '0;
        ifc.mac_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_ack", 32'(ifc.ack), 32'd0);
        check("rst_err", 32'(ifc.err), 32'd0);
        check("rst_starts", 32'(starts()), 32'd0);
        check("rst_grant", 32'(ifc.grant_id), 32'd0);
        check("rst_ops", 32'(ifc.ops_done), 32'd0);

        // Single mat16 op from requester 2
        ifc.req       = 4'b0100;
        ifc.op[8:6]   = 3'd3;
        tick();
        check("single_start", 32'(starts()), 32'b01000);
        check("single_grant", 32'(ifc.grant_id), 32'd2);
        check("single_busy", 32'(ifc.busy), 32'd1);
        tick();
        check("single_pulse_width", 32'(starts()), 32'd0);
        repeat (9) tick();
        ifc.mac_done = 1'b1;
        tick();
        ifc.mac_done = 1'b0;
        ifc.req      = '0;
        check("single_ack", 32'(ifc.ack), 32'b0100);
        check("single_err", 32'(ifc.err), 32'd0);
        tick();
        check("single_ack_clr", 32'(ifc.ack), 32'd0);
        check("single_idle", 32'(ifc.busy), 32'd0);
        check("single_ops", 32'(ifc.ops_done), 32'd1);

        // Illegal opcode from requester 1
        ifc.req     = 4'b0010;
        ifc.op[5:3] = 3'd6;
        tick();
        check("illegal_ack", 32'(ifc.ack), 32'b0010);
        check("illegal_err", 32'(ifc.err), 32'd1);
        check("illegal_nostart", 32'(starts()), 32'd0);
        ifc.req = '0;
        tick();
        check("illegal_idle", 32'(ifc.busy), 32'd0);
        check("illegal_ops", 32'(ifc.ops_done), 32'd1);
        check("illegal_err_clr", 32'(ifc.err), 32'd0);

        // Timeout: done never arrives
        ifc.req      = 4'b1000;
        ifc.op[11:9] = 3'd4;
        tick();
        check("to_start", 32'(starts()), 32'b10000);
        check("to_grant", 32'(ifc.grant_id), 32'd3);
        n = 0;
        do begin
            tick();
            n++;
        end while (ifc.ack == '0 && n < 40);
        check("to_latency", 32'(n), 32'd17);
        check("to_ack", 32'(ifc.ack), 32'b1000);
        check("to_err", 32'(ifc.err), 32'd1);
        ifc.req = '0;
        tick();
        check("to_idle", 32'(ifc.busy), 32'd0);
        check("to_ops", 32'(ifc.ops_done), 32'd1);

        // Normal op after timeout; done during ISSUE must be ignored
        ifc.req     = 4'b0001;
        ifc.op[2:0] = 3'd0;
        tick();
        check("post_to_start", 32'(starts()), 32'b00001);
        check("post_to_grant", 32'(ifc.grant_id), 32'd0);
        ifc.mac_done = 1'b1;
        tick();
        ifc.mac_done = 1'b0;
        check("issue_done_ignored_ack", 32'(ifc.ack), 32'd0);
        check("issue_done_ignored_busy", 32'(ifc.busy), 32'd1);
        repeat (2) tick();
        check("issue_done_still_wait", 32'(ifc.ack), 32'd0);
        ifc.mac_done = 1'b1;
        tick();
        ifc.mac_done = 1'b0;
        ifc.req      = '0;
        check("post_to_ack", 32'(ifc.ack), 32'b0001);
        check("post_to_err", 32'(ifc.err), 32'd0);
        tick();
        check("post_to_ops", 32'(ifc.ops_done), 32'd2);

        // Spurious done while idle
        ifc.mac_done = 1'b1;
        tick();
        ifc.mac_done = 1'b0;
        check("spur_busy", 32'(ifc.busy), 32'd0);
        check("spur_ack", 32'(ifc.ack), 32'd0);
        tick();
        check("spur_ack2", 32'(ifc.ack), 32'd0);
        check("spur_ops", 32'(ifc.ops_done), 32'd2);

        // Requester 0 drops req during WAIT but still gets ack
        ifc.req     = 4'b0001;
        ifc.op[2:0] = 3'd1;
        tick();
        check("drop_start", 32'(starts()), 32'b00010);
        tick();
        ifc.req = '0;
        repeat (3) tick();
        check("drop_busy", 32'(ifc.busy), 32'd1);
        ifc.mac_done = 1'b1;
        tick();
        ifc.mac_done = 1'b0;
        check("drop_ack", 32'(ifc.ack), 32'b0001);
        tick();
        check("drop_ops", 32'(ifc.ops_done), 32'd3);
        check("drop_idle", 32'(ifc.busy), 32'd0);

        // Reset mid-WAIT
        ifc.req     = 4'b0100;
        ifc.op[8:6] = 3'd2;
        tick();
        check("rstw_start", 32'(starts()), 32'b00100);
        repeat (2) tick();
        ifc.req = '0;
        rst     = 1'b1;
        #1;
        check("rstw_busy", 32'(ifc.busy), 32'd0);
        check("rstw_ack", 32'(ifc.ack), 32'd0);
        check("rstw_ops", 32'(ifc.ops_done), 32'd0);
        check("rstw_grant", 32'(ifc.grant_id), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rstw_no_ack", 32'(ifc.ack), 32'd0);

        // Fairness: all requesting, opcode i on requester i
        ifc.op  = {3'd3, 3'd2, 3'd1, 3'd0};
        ifc.req = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (starts() == '0 && n < 10);
            check("fair_grant", 32'(ifc.grant_id), 32'(g % 4));
            check("fair_start", 32'(starts()), 32'(1) << (g % 4));
            if (g > 0) check("fair_b2b_gap", 32'(n), 32'd2);
            repeat (5) tick();
            ifc.mac_done = 1'b1;
            tick();
            ifc.mac_done = 1'b0;
            check("fair_ack", 32'(ifc.ack), 32'(1) << (g % 4));
        end
        ifc.req = '0;
        repeat (2) tick();
        check("fair_ops", 32'(ifc.ops_done), 32'd6);
        check("fair_idle", 32'(ifc.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
